// File: rtl/wb_dma_arbiter.sv
// Two-master round-robin Wishbone arbiter: m0 = management CPU, m1 = length-bounded DMA bursts.
// Define ARB_TIMEOUT_EN to add a per-grant watchdog that aborts a hung slave transfer.
module wb_dma_arbiter #(
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [31:0]      m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  output logic             m0_ack_o,
  output logic [31:0]      m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [31:0]      m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  input  logic [LEN_W-1:0] m1_burst_len_i,
  output logic             m1_ack_o,
  output logic [31:0]      m1_dat_o,
  output logic             m1_burst_done_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [31:0]      s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic             s_ack_i,
  input  logic [31:0]      s_dat_i,
  output logic [1:0]       grant_o
`ifdef ARB_TIMEOUT_EN
  , output logic           timeout_o
`endif
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state, state_nxt;
  logic             last_grant;  // 1: m1 held the most recent grant
  logic [LEN_W-1:0] len, beat_cnt, beat_cnt_nxt;
  logic             req0, req1, beat_hit, abort;

  assign req0     = m0_cyc_i & m0_stb_i;
  assign req1     = m1_cyc_i & m1_stb_i;
  assign beat_hit = (len != '0) && ((beat_cnt + LEN_W'(1)) == len);

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog;
  logic            stall;

  assign stall = ((state == GNT0 && m0_stb_i) || (state == GNT1 && m1_stb_i)) &&
                 !s_ack_i && !wb_rst_i;
  // Fires on the TIMEOUT_CYC-th consecutive stalled cycle.
  assign abort     = stall && (wdog == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_o = abort;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_nxt == IDLE || s_ack_i) wdog <= '0;
    else if (stall)                              wdog <= wdog + WD_W'(1);
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    beat_cnt_nxt    = beat_cnt;
    grant_o         = 2'b00;
    s_cyc_o         = 1'b0;
    s_stb_o         = 1'b0;
    s_we_o          = 1'b0;
    s_sel_o         = '0;
    s_adr_o         = '0;
    s_dat_o         = '0;
    m0_ack_o        = 1'b0;
    m0_dat_o        = '0;
    m1_ack_o        = 1'b0;
    m1_dat_o        = '0;
    m1_burst_done_o = 1'b0;
    if (wb_rst_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_grant)) state_nxt = GNT0;
          else if (req1)                     state_nxt = GNT1;
        end
        GNT0: begin
          grant_o  = 2'b01;
          s_cyc_o  = m0_cyc_i;
          s_stb_o  = m0_stb_i;
          s_we_o   = m0_we_i;
          s_sel_o  = m0_sel_i;
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          m0_ack_o = s_ack_i | abort;
          m0_dat_o = abort ? 32'hDEAD_BEEF : s_dat_i;
          if (abort || !m0_cyc_i) state_nxt = IDLE;
        end
        GNT1: begin
          grant_o  = 2'b10;
          s_cyc_o  = m1_cyc_i;
          s_stb_o  = m1_stb_i;
          s_we_o   = m1_we_i;
          s_sel_o  = m1_sel_i;
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          m1_ack_o = s_ack_i | abort;
          m1_dat_o = abort ? 32'hDEAD_BEEF : s_dat_i;
          if (abort) begin
            state_nxt = IDLE;
          end else begin
            if (s_ack_i) begin
              beat_cnt_nxt = (beat_cnt == '1) ? beat_cnt : beat_cnt + LEN_W'(1);
              if (beat_hit) begin
                m1_burst_done_o = 1'b1;
                state_nxt       = IDLE;
              end
            end
            if (!m1_cyc_i) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      len        <= '0;
      beat_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (state == IDLE && state_nxt == GNT0) last_grant <= 1'b0;
      if (state == IDLE && state_nxt == GNT1) begin
        last_grant <= 1'b1;
        len        <= m1_burst_len_i;
        beat_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Bench for wb_dma_arbiter: scripted masters, a delay-programmable slave and a read-data scoreboard.
module tb_wb_dma_arbiter;
  localparam int LEN_W = 8;

  logic             wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic             m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o;
  logic [3:0]       m0_sel_i;
  logic [31:0]      m0_adr_i, m0_dat_i, m0_dat_o;
  logic             m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_burst_done_o;
  logic [3:0]       m1_sel_i;
  logic [31:0]      m1_adr_i, m1_dat_i, m1_dat_o;
  logic [LEN_W-1:0] m1_burst_len_i;
  logic             s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]       grant_o;
`ifdef ARB_TIMEOUT_EN
  logic             timeout_o;
`endif

  wb_dma_arbiter #(.LEN_W(LEN_W), .TIMEOUT_CYC(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_burst_len_i(m1_burst_len_i),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o), .m1_burst_done_o(m1_burst_done_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
`ifdef ARB_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errs = 0, chks = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Slave: ack slv_dly cycles after strobe is seen; 0 = ack every strobed cycle.
  int slv_dly = 2, wcnt = 0;
  bit slv_hang = 0;
  initial begin
    s_ack_i = 1'b0; s_dat_i = '0;
    forever begin
      @(posedge wb_clk_i); #2;
      if (!(s_cyc_o && s_stb_o) || slv_hang) begin s_ack_i = 1'b0; wcnt = 0; end
      else if (slv_dly == 0)                 s_ack_i = 1'b1;
      else if (s_ack_i)                      begin s_ack_i = 1'b0; wcnt = 0; end
      else if (wcnt == slv_dly)              s_ack_i = 1'b1;
      else                                   wcnt++;
      s_dat_i = s_ack_i ? rdat(s_adr_o) : '0;
    end
  end

  // Scoreboard: every ack must match the next expected read word for that master.
  logic [31:0] q0[$], q1[$];
  int n_ack0 = 0, n_ack1 = 0, n_done = 0;
  initial forever begin
    @(negedge wb_clk_i);
    if (m0_ack_o) begin
      n_ack0++;
      if (q0.size() == 0) chk("m0_ack_unexp", 32'(m0_ack_o), 32'd0);
      else                chk("m0_dat", m0_dat_o, q0.pop_front());
    end
    if (m1_ack_o) begin
      n_ack1++;
      if (q1.size() == 0) chk("m1_ack_unexp", 32'(m1_ack_o), 32'd0);
      else                chk("m1_dat", m1_dat_o, q1.pop_front());
    end
    if (m1_burst_done_o) n_done++;
    if (grant_o != 2'b01) chk("m0_quiet", {m0_dat_o[30:0], m0_ack_o}, 32'd0);
    if (grant_o != 2'b10) chk("m1_quiet", {m1_dat_o[30:0], m1_ack_o}, 32'd0);
  end

  task automatic m0_start(input logic [31:0] a, d, input logic we, input logic [31:0] exp);
    m0_adr_i = a; m0_dat_i = d; m0_we_i = we; m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    q0.push_back(exp);
  endtask
  task automatic m0_end;
    @(posedge wb_clk_i); #1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
  endtask
  task automatic wait_ack0(input int lim, output int lat);
    lat = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge wb_clk_i);
      if (m0_ack_o) begin lat = i; break; end
    end
  endtask
  task automatic m1_start(input logic [31:0] a, input logic [LEN_W-1:0] l, input int beats);
    m1_adr_i = a; m1_dat_i = ~a; m1_we_i = 1'b0; m1_sel_i = 4'hF; m1_burst_len_i = l;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int i = 0; i < beats; i++) q1.push_back(rdat(a));
  endtask
  task automatic m1_stop;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
  endtask
  task automatic run_m1(input int lim, input int stop_at, output int acks, output int done_at);
    acks = 0; done_at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge wb_clk_i);
      if (m1_ack_o) acks++;
      if (m1_burst_done_o) begin done_at = acks; break; end
      if (stop_at > 0 && acks == stop_at) break;
    end
  endtask
  task automatic tick;
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "bench hung");
  end

  int lat, acks, done_at, snap;
  initial begin
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    m1_burst_len_i = 0;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_scyc",  32'({s_cyc_o, s_stb_o, s_we_o}), 32'd0);
    chk("rst_done",  32'(m1_burst_done_o), 32'd0);

    // m0 single write, slave acks 2 cycles after strobe
    tick(); m0_start(32'h3000_0004, 32'h1234_5678, 1'b1, rdat(32'h3000_0004));
    @(negedge wb_clk_i); chk("t1_arb_lat", 32'(grant_o), 32'd0);
    @(negedge wb_clk_i);
    chk("t1_grant", 32'(grant_o), 32'd1);
    chk("t1_sadr",  s_adr_o, 32'h3000_0004);
    chk("t1_sdat",  s_dat_o, 32'h1234_5678);
    chk("t1_swe",   32'({s_cyc_o, s_stb_o, s_we_o}), 32'd7);
    wait_ack0(20, lat); chk("t1_ack_lat", 32'(lat), 32'd1);
    m0_end();
    @(negedge wb_clk_i); chk("t1_scyc_drop", 32'(s_cyc_o), 32'd0);
    @(negedge wb_clk_i); chk("t1_idle", 32'(grant_o), 32'd0);
    chk("t1_ack_once", 32'(n_ack0), 32'd1);

    // simultaneous request right after reset: m0 first, then idle, then m1
    wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0; slv_dly = 1;
    m0_start(32'h3000_0010, 32'h0, 1'b0, rdat(32'h3000_0010));
    m1_start(32'h3000_0100, 8'd3, 3);
    @(negedge wb_clk_i); chk("t2_pre", 32'(grant_o), 32'd0);
    @(negedge wb_clk_i); chk("t2_m0_first", 32'(grant_o), 32'd1);
    wait_ack0(20, lat); chk("t2_m0_lat", 32'(lat), 32'd0);
    m0_end();
    @(negedge wb_clk_i); chk("t2_hold", 32'(grant_o), 32'd1);
    @(negedge wb_clk_i); chk("t2_gap", 32'(grant_o), 32'd0);
    @(negedge wb_clk_i); chk("t2_m1", 32'(grant_o), 32'd2);
    run_m1(40, 0, acks, done_at);
    chk("t2_acks", 32'(acks), 32'd3); chk("t2_done_at", 32'(done_at), 32'd3);
    tick(); m1_stop();
    @(negedge wb_clk_i); chk("t2_idle", 32'(grant_o), 32'd0);

    // len=4 burst with cyc held, back-to-back acks, m0 pending during the burst
    slv_dly = 0; tick();
    m1_start(32'h3000_0200, 8'd4, 4);
    @(negedge wb_clk_i); chk("t3_pre", 32'(grant_o), 32'd0);
    tick(); m0_start(32'h3000_0020, 32'h0, 1'b0, rdat(32'h3000_0020));
    snap = n_ack0;
    run_m1(20, 0, acks, done_at);
    chk("t3_acks", 32'(acks), 32'd4); chk("t3_done_at", 32'(done_at), 32'd4);
    chk("t3_done_ack", 32'(m1_ack_o), 32'd1);
    @(negedge wb_clk_i); chk("t3_gap", 32'(grant_o), 32'd0);
    chk("t3_gap_ack", 32'(m1_ack_o), 32'd0);
    @(negedge wb_clk_i); chk("t3_m0_next", 32'(grant_o), 32'd1);
    chk("t3_m0_ack", 32'(m0_ack_o), 32'd1);
    m0_end(); m1_stop();
    @(negedge wb_clk_i); @(negedge wb_clk_i); chk("t3_idle", 32'(grant_o), 32'd0);
    chk("t3_m0_once", 32'(n_ack0 - snap), 32'd1);

    // len=0: unbounded, ten beats then cyc drop, no done pulse
    tick(); snap = n_done;
    m1_start(32'h3000_0300, 8'd0, 10);
    run_m1(40, 10, acks, done_at);
    chk("t4_acks", 32'(acks), 32'd10); chk("t4_no_done", 32'(done_at), 32'hFFFF_FFFF);
    tick(); m1_stop();
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    chk("t4_idle", 32'(grant_o), 32'd0);
    chk("t4_done_cnt", 32'(n_done - snap), 32'd0);

    // reset mid-burst (after beat 2 of 8), then restart with a fresh count
    tick(); m1_start(32'h3000_0400, 8'd8, 8);
    run_m1(20, 2, acks, done_at); chk("t5_pre_acks", 32'(acks), 32'd2);
    tick(); wb_rst_i = 1'b1;
    @(negedge wb_clk_i); chk("t5_rst_noack", 32'(m1_ack_o), 32'd0);
    tick(); wb_rst_i = 1'b0; q1.delete();
    m1_start(32'h3000_0500, 8'd3, 3);
    @(negedge wb_clk_i);
    chk("t5_grant", 32'(grant_o), 32'd0);
    chk("t5_s_out", s_adr_o | s_dat_o | 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
    chk("t5_m_out", 32'({m0_ack_o, m1_ack_o, m1_burst_done_o}), 32'd0);
    run_m1(20, 0, acks, done_at);
    chk("t5_acks", 32'(acks), 32'd3); chk("t5_done_at", 32'(done_at), 32'd3);
    tick(); m1_stop();
    @(negedge wb_clk_i); chk("t5_idle", 32'(grant_o), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // hung slave on an m0 read: abort on the 16th stalled cycle
    slv_hang = 1; tick();
    m0_start(32'h3000_0600, 32'h0, 1'b0, 32'hDEAD_BEEF);
    @(negedge wb_clk_i); chk("t6_pre_to", 32'(timeout_o), 32'd0);
    wait_ack0(40, lat);
    chk("t6_lat", 32'(lat), 32'd15);
    chk("t6_to", 32'(timeout_o), 32'd1);
    chk("t6_dat", m0_dat_o, 32'hDEAD_BEEF);
    m0_end();
    @(negedge wb_clk_i);
    chk("t6_idle", 32'(grant_o), 32'd0);
    chk("t6_to_off", 32'(timeout_o), 32'd0);
    slv_hang = 0;
`endif

    repeat (3) @(negedge wb_clk_i);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
